// File: rtl/sad_datapath.sv
// SAD datapath: two N-entry pixel register files, |A-B| accumulator, result register.
// Optional SAD_MIN_TRACK_EN adds running-minimum tracking (min_sad/min_upd).
module sad_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int SUM_W  = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              Mrst,
    input  logic              rst,
    input  logic              en,
    input  logic              en_reg,
    input  logic              ld_we,
    input  logic              ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              comp,
`ifdef SAD_MIN_TRACK_EN
    output logic [SUM_W-1:0]  min_sad,
    output logic              min_upd,
`endif
    output logic [SUM_W-1:0]  sad,
    output logic              sad_valid
);

    localparam int unsigned N = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] IDX_END = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem_a [N];
    logic [DATA_W-1:0] mem_b [N];

    logic [ADDR_W:0]   idx;
    logic [SUM_W-1:0]  acc;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] diff;

    assign comp = (idx == IDX_END);

    // Once idx reaches N its low bits wrap to 0; the read is harmless since en is then ignored.
    always_comb begin
        rd_a = mem_a[idx[ADDR_W-1:0]];
        rd_b = mem_b[idx[ADDR_W-1:0]];
        diff = (rd_a >= rd_b) ? (rd_a - rd_b) : (rd_b - rd_a);
    end

    always_ff @(posedge clk) begin
        if (ld_we && !Mrst) begin
            if (ld_sel)
                mem_b[ld_addr] <= ld_data;
            else
                mem_a[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (Mrst) begin
            idx       <= '0;
            acc       <= '0;
            sad       <= '0;
            sad_valid <= 1'b0;
        end else begin
            if (rst) begin
                idx <= '0;
                acc <= '0;
            end else if (en && !comp) begin
                acc <= acc + SUM_W'(diff);
                idx <= idx + 1'b1;
            end
            sad_valid <= en_reg;
            if (en_reg)
                sad <= acc;
        end
    end

`ifdef SAD_MIN_TRACK_EN
    logic min_seen;

    always_ff @(posedge clk) begin
        if (Mrst) begin
            min_sad  <= '0;
            min_seen <= 1'b0;
            min_upd  <= 1'b0;
        end else begin
            min_upd <= 1'b0;
            if (en_reg && (!min_seen || acc < min_sad)) begin
                min_sad  <= acc;
                min_seen <= 1'b1;
                min_upd  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sad_datapath.sv
// Directed self-checking bench for sad_datapath (N=16 defaults).
module tb_sad_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int SUM_W  = DATA_W + ADDR_W;

    logic              clk = 1'b0;
    logic              Mrst = 1'b1;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              en_reg = 1'b0;
    logic              ld_we = 1'b0;
    logic              ld_sel = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              comp;
    logic [SUM_W-1:0]  sad;
    logic              sad_valid;
`ifdef SAD_MIN_TRACK_EN
    logic [SUM_W-1:0]  min_sad;
    logic              min_upd;
    logic [SUM_W-1:0]  last_min_sad;
    logic              last_min_upd;
`endif

    int checks = 0;
    int errors = 0;

    sad_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .Mrst(Mrst), .rst(rst), .en(en), .en_reg(en_reg),
        .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .comp(comp),
`ifdef SAD_MIN_TRACK_EN
        .min_sad(min_sad), .min_upd(min_upd),
`endif
        .sad(sad), .sad_valid(sad_valid)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input logic sel, input int addr, input int data);
        ld_we = 1'b1; ld_sel = sel;
        ld_addr = ADDR_W'(addr); ld_data = DATA_W'(data);
        cycle();
        ld_we = 1'b0;
    endtask

    // mode 0: 10/3, 1: k/15-k, 2: 255/0, 3: A=3 (A[0]=5) / B=0 -> SAD 50
    task automatic load_blocks(input int mode);
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0: begin write_mem(1'b0, k, 10); write_mem(1'b1, k, 3); end
                1: begin write_mem(1'b0, k, k); write_mem(1'b1, k, 15 - k); end
                2: begin write_mem(1'b0, k, 255); write_mem(1'b1, k, 0); end
                default: begin write_mem(1'b0, k, (k == 0) ? 5 : 3); write_mem(1'b1, k, 0); end
            endcase
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1; cycle(); rst = 1'b0;
    endtask

    task automatic pulse_en();
        en = 1'b1; cycle(); en = 1'b0;
    endtask

    task automatic latch_and_check(input string name, input logic [SUM_W-1:0] exp);
        en_reg = 1'b1; cycle(); en_reg = 1'b0;
`ifdef SAD_MIN_TRACK_EN
        last_min_sad = min_sad;
        last_min_upd = min_upd;
`endif
        checks++;
        if (sad !== exp || sad_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: sad=%0d valid=%b, expected sad=%0d valid=1", name, sad, sad_valid, exp);
        end
        cycle();
        checks++;
        if (sad_valid !== 1'b0 || sad !== exp) begin
            errors++;
            $display("FAIL %s_pulse: valid=%b sad=%0d, expected valid=0 sad=%0d", name, sad_valid, sad, exp);
        end
    endtask

    // Full run with idle cycles between strobes; comp checked before and after each en.
    task automatic run_full(input string name, input logic [SUM_W-1:0] exp);
        bit comp_ok = 1'b1;
        pulse_rst();
        for (int k = 0; k < 16; k++) begin
            if (comp !== 1'b0) comp_ok = 1'b0;
            pulse_en();
            cycle();
        end
        checks++;
        if (!comp_ok || comp !== 1'b1) begin
            errors++;
            $display("FAIL %s_comp: early_ok=%b comp=%b, expected early_ok=1 comp=1", name, comp_ok, comp);
        end
        latch_and_check(name, exp);
    endtask

    task automatic test_reset();
        cycle(); cycle();
        checks++;
        if (sad !== '0 || sad_valid !== 1'b0 || comp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sad=%0d valid=%b comp=%b, expected 0 0 0", sad, sad_valid, comp);
        end
        Mrst = 1'b0;
        load_blocks(0);
        // Load attempt under reset must not land: A[0]=200 would give 302.
        Mrst = 1'b1; ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'd200;
        cycle(); cycle();
        ld_we = 1'b0; Mrst = 1'b0;
        run_full("reset_load_ignored", 12'd112);
    endtask

    task automatic test_patterns();
        load_blocks(0);
        run_full("pat_10_3", 12'd112);
        load_blocks(1);
        run_full("pat_both_dirs", 12'd128);
        load_blocks(2);
        run_full("pat_max", 12'd4080);
    endtask

    task automatic test_abort_and_saturate();
        load_blocks(0);
        pulse_rst();
        repeat (5) pulse_en();
        pulse_rst();
        checks++;
        if (comp !== 1'b0) begin
            errors++;
            $display("FAIL abort_comp: comp=%b, expected 0", comp);
        end
        latch_and_check("abort_acc_cleared", 12'd0);
        // Extra strobes after comp=1 must not add
        pulse_rst();
        repeat (19) pulse_en();
        checks++;
        if (comp !== 1'b1) begin
            errors++;
            $display("FAIL saturate_comp: comp=%b, expected 1", comp);
        end
        latch_and_check("saturate", 12'd112);
        // rst + en_reg on the same edge: sad gets pre-clear acc
        rst = 1'b1; en_reg = 1'b1; cycle(); rst = 1'b0; en_reg = 1'b0;
        checks++;
        if (sad !== 12'd112 || sad_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_with_en_reg: sad=%0d valid=%b, expected 112 1", sad, sad_valid);
        end
        latch_and_check("after_rst_cleared", 12'd0);
    endtask

    task automatic test_back_to_back();
        load_blocks(0);
        pulse_rst();
        pulse_en();
        // en + en_reg on the same edge: sad takes pre-add acc
        en = 1'b1; en_reg = 1'b1; cycle(); en = 1'b0; en_reg = 1'b0;
        checks++;
        if (sad !== 12'd7 || sad_valid !== 1'b1) begin
            errors++;
            $display("FAIL en_with_en_reg: sad=%0d valid=%b, expected 7 1", sad, sad_valid);
        end
        latch_and_check("en_reg_follow", 12'd14);
    endtask

    task automatic test_load_mid_run();
        load_blocks(0);
        pulse_rst();
        repeat (3) pulse_en();
        write_mem(1'b0, 5, 20);
        repeat (13) pulse_en();
        latch_and_check("load_mid_run", 12'd122);
    endtask

    task automatic test_mrst_mid_run();
        load_blocks(0);
        run_full("pre_mrst", 12'd112);
        pulse_rst();
        repeat (5) pulse_en();
        Mrst = 1'b1; cycle(); Mrst = 1'b0;
        checks++;
        if (sad !== '0 || sad_valid !== 1'b0 || comp !== 1'b0) begin
            errors++;
            $display("FAIL mrst_mid_run: sad=%0d valid=%b comp=%b, expected 0 0 0", sad, sad_valid, comp);
        end
        latch_and_check("mrst_acc_cleared", 12'd0);
    endtask

`ifdef SAD_MIN_TRACK_EN
    task automatic check_min(input string name, input logic [SUM_W-1:0] exp_min, input logic exp_upd);
        checks++;
        if (last_min_sad !== exp_min || last_min_upd !== exp_upd) begin
            errors++;
            $display("FAIL %s: min_sad=%0d upd=%b, expected min_sad=%0d upd=%b",
                     name, last_min_sad, last_min_upd, exp_min, exp_upd);
        end
    endtask

    task automatic test_min_track();
        Mrst = 1'b1; cycle(); Mrst = 1'b0;
        checks++;
        if (min_sad !== '0 || min_upd !== 1'b0) begin
            errors++;
            $display("FAIL min_reset: min_sad=%0d upd=%b, expected 0 0", min_sad, min_upd);
        end
        load_blocks(0);
        run_full("min_run1", 12'd112);
        check_min("min_after_112", 12'd112, 1'b1);
        load_blocks(1);
        run_full("min_run2", 12'd128);
        check_min("min_after_128", 12'd112, 1'b0);
        load_blocks(3);
        run_full("min_run3", 12'd50);
        check_min("min_after_50", 12'd50, 1'b1);
        run_full("min_run4", 12'd50);
        check_min("min_tie_50", 12'd50, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_patterns();
        test_abort_and_saturate();
        test_back_to_back();
        test_load_mid_run();
        test_mrst_mid_run();
`ifdef SAD_MIN_TRACK_EN
        test_min_track();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
